// File: rtl/cluster_bbox_builder.sv
// Accumulates per-cluster min/max/count from a point stream and emits one 3D box per cluster.
// Optional macro BBOX_MARGIN_EN expands each emitted box by MARGIN per side, saturating.
module cluster_bbox_builder #(
    parameter int                 CNT_W      = 12,
    parameter int                 MIN_POINTS = 3,
    parameter logic signed [15:0] MARGIN     = 16'sh0020
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pt_valid_in,
    output logic                    pt_ready_out,
    input  logic signed [15:0]      pt_x,
    input  logic signed [15:0]      pt_y,
    input  logic signed [15:0]      pt_z,
    input  logic                    pt_last,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic signed [15:0]      min_x,
    output logic signed [15:0]      min_y,
    output logic signed [15:0]      min_z,
    output logic signed [15:0]      max_x,
    output logic signed [15:0]      max_y,
    output logic signed [15:0]      max_z,
    output logic [CNT_W-1:0]        point_count,
    output logic                    dropped_out
);

    localparam int DATA_W = 16;

    typedef enum logic {ACC_EMPTY, ACC_RUN} acc_state_t;

    acc_state_t state, state_nxt;

    logic signed [DATA_W-1:0] pt_p0      [3];
    logic signed [DATA_W-1:0] mrg_min_p0 [3];
    logic signed [DATA_W-1:0] mrg_max_p0 [3];
    logic signed [DATA_W-1:0] box_min_p0 [3];
    logic signed [DATA_W-1:0] box_max_p0 [3];
    logic signed [DATA_W-1:0] acc_min_p1 [3];
    logic signed [DATA_W-1:0] acc_max_p1 [3];
    logic signed [DATA_W-1:0] out_min_p1 [3];
    logic signed [DATA_W-1:0] out_max_p1 [3];
    logic [CNT_W-1:0]         acc_cnt_p1;
    logic [CNT_W-1:0]         mrg_cnt_p0;
    logic                     accept_p0;
    logic                     close_p0;
    logic                     emit_p0;

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [DATA_W:0] v);
        if (v > 17'sd32767)
            return 16'sh7FFF;
        else if (v < -17'sd32768)
            return 16'sh8000;
        else
            return v[DATA_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}})
            return c;
        else
            return c + CNT_W'(1);
    endfunction

    assign pt_ready_out = ~rst & (~valid_out | ready_in);
    assign accept_p0    = pt_valid_in & pt_ready_out;
    assign close_p0     = accept_p0 & pt_last;

    assign pt_p0[0] = pt_x;
    assign pt_p0[1] = pt_y;
    assign pt_p0[2] = pt_z;

    // Stage p0: merge the incoming point into the running box
    always_comb begin
        for (int a = 0; a < 3; a++) begin
            mrg_min_p0[a] = pt_p0[a];
            mrg_max_p0[a] = pt_p0[a];
            if (state == ACC_RUN) begin
                if (!(pt_p0[a] < acc_min_p1[a]))
                    mrg_min_p0[a] = acc_min_p1[a];
                if (!(pt_p0[a] > acc_max_p1[a]))
                    mrg_max_p0[a] = acc_max_p1[a];
            end
        end
        mrg_cnt_p0 = (state == ACC_RUN) ? cnt_inc(acc_cnt_p1) : CNT_W'(1);
    end

    assign emit_p0 = close_p0 && (int'(mrg_cnt_p0) >= MIN_POINTS);

`ifdef BBOX_MARGIN_EN
    always_comb begin
        for (int a = 0; a < 3; a++) begin
            box_min_p0[a] = sat16($signed({mrg_min_p0[a][DATA_W-1], mrg_min_p0[a]})
                                  - $signed({MARGIN[DATA_W-1], MARGIN}));
            box_max_p0[a] = sat16($signed({mrg_max_p0[a][DATA_W-1], mrg_max_p0[a]})
                                  + $signed({MARGIN[DATA_W-1], MARGIN}));
        end
    end
`else
    logic unused_margin;
    assign unused_margin = ^MARGIN;

    always_comb begin
        for (int a = 0; a < 3; a++) begin
            box_min_p0[a] = mrg_min_p0[a];
            box_max_p0[a] = mrg_max_p0[a];
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        if (accept_p0)
            state_nxt = pt_last ? ACC_EMPTY : ACC_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ACC_EMPTY;
        else
            state <= state_nxt;
    end

    // Stage p1: accumulator registers; corners are only meaningful while in ACC_RUN
    always_ff @(posedge clk) begin
        if (rst)
            acc_cnt_p1 <= '0;
        else if (accept_p0 && !pt_last)
            acc_cnt_p1 <= mrg_cnt_p0;
    end

    always_ff @(posedge clk) begin
        if (accept_p0 && !pt_last) begin
            for (int a = 0; a < 3; a++) begin
                acc_min_p1[a] <= mrg_min_p0[a];
                acc_max_p1[a] <= mrg_max_p0[a];
            end
        end
    end

    // Stage p1: output buffer, reloaded directly on a same-cycle close and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out   <= 1'b0;
            dropped_out <= 1'b0;
            point_count <= '0;
            for (int a = 0; a < 3; a++) begin
                out_min_p1[a] <= '0;
                out_max_p1[a] <= '0;
            end
        end else begin
            dropped_out <= close_p0 & ~emit_p0;
            if (emit_p0) begin
                valid_out   <= 1'b1;
                point_count <= mrg_cnt_p0;
                for (int a = 0; a < 3; a++) begin
                    out_min_p1[a] <= box_min_p0[a];
                    out_max_p1[a] <= box_max_p0[a];
                end
            end else if (ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

    assign min_x = out_min_p1[0];
    assign min_y = out_min_p1[1];
    assign min_z = out_min_p1[2];
    assign max_x = out_max_p1[0];
    assign max_y = out_max_p1[1];
    assign max_z = out_max_p1[2];

endmodule

// File: tb/tb_cluster_bbox_builder.sv
// Directed bench for cluster_bbox_builder: a default instance plus a MIN_POINTS=1 instance
// used for single-point and back-to-back boxes.
module tb_cluster_bbox_builder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               pt_valid_in, pt_ready_out, pt_last, valid_out, ready_in, dropped_out;
    logic signed [15:0] pt_x, pt_y, pt_z;
    logic signed [15:0] min_x, min_y, min_z, max_x, max_y, max_z;
    logic [11:0]        point_count;

    logic               b_valid_in, b_ready_out, b_last, b_valid_out, b_ready_in, b_dropped;
    logic signed [15:0] b_x, b_y, b_z;
    logic signed [15:0] b_min_x, b_min_y, b_min_z, b_max_x, b_max_y, b_max_z;
    logic [11:0]        b_count;

    int n_cmp = 0;
    int n_err = 0;

    cluster_bbox_builder u_dut (
        .clk(clk), .rst(rst),
        .pt_valid_in(pt_valid_in), .pt_ready_out(pt_ready_out),
        .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z), .pt_last(pt_last),
        .valid_out(valid_out), .ready_in(ready_in),
        .min_x(min_x), .min_y(min_y), .min_z(min_z),
        .max_x(max_x), .max_y(max_y), .max_z(max_z),
        .point_count(point_count), .dropped_out(dropped_out)
    );

    cluster_bbox_builder #(.MIN_POINTS(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .pt_valid_in(b_valid_in), .pt_ready_out(b_ready_out),
        .pt_x(b_x), .pt_y(b_y), .pt_z(b_z), .pt_last(b_last),
        .valid_out(b_valid_out), .ready_in(b_ready_in),
        .min_x(b_min_x), .min_y(b_min_y), .min_z(b_min_z),
        .max_x(b_max_x), .max_y(b_max_y), .max_z(b_max_z),
        .point_count(b_count), .dropped_out(b_dropped)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_box(input string tag,
                           input logic [15:0] mnx, input logic [15:0] mny, input logic [15:0] mnz,
                           input logic [15:0] mxx, input logic [15:0] mxy, input logic [15:0] mxz,
                           input logic [15:0] cnt);
        chk({tag, ".valid"}, 16'(valid_out), 16'd1);
        chk({tag, ".min_x"}, min_x, mnx);
        chk({tag, ".min_y"}, min_y, mny);
        chk({tag, ".min_z"}, min_z, mnz);
        chk({tag, ".max_x"}, max_x, mxx);
        chk({tag, ".max_y"}, max_y, mxy);
        chk({tag, ".max_z"}, max_z, mxz);
        chk({tag, ".count"}, 16'(point_count), cnt);
    endtask

    // Presents one point and returns 1 ns after the edge that accepted it.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic last);
        int budget = 50;
        pt_valid_in = 1'b1;
        pt_x = x; pt_y = y; pt_z = z; pt_last = last;
        #1;
        while (!pt_ready_out && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0)
            chk("send_timeout", 16'(pt_ready_out), 16'd1);
        @(posedge clk); #1;
        pt_valid_in = 1'b0;
        pt_last     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pt_valid_in = 0; pt_last = 0; pt_x = 0; pt_y = 0; pt_z = 0; ready_in = 0;
        b_valid_in = 0; b_last = 0; b_x = 0; b_y = 0; b_z = 0; b_ready_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", 16'(valid_out), 16'd0);
        chk("rst.dropped", 16'(dropped_out), 16'd0);
        chk("rst.ready", 16'(pt_ready_out), 16'd0);
        chk("rst.min_x", min_x, 16'h0000);
        chk("rst.max_z", max_z, 16'h0000);
        chk("rst.count", 16'(point_count), 16'd0);
        rst = 1'b0;
        ready_in = 1'b1;
        #1;
        chk("idle.ready", 16'(pt_ready_out), 16'd1);

        // Basic 3-point cluster
        send(16'h0100, 16'h0200, 16'hFF80, 1'b0);
        chk("basic.no_early_valid", 16'(valid_out), 16'd0);
        send(16'hFD00, 16'h0400, 16'h0010, 1'b0);
        send(16'h0050, 16'hFF00, 16'h0020, 1'b1);
        chk_box("basic", 16'hFD00, 16'hFF00, 16'hFF80, 16'h0100, 16'h0400, 16'h0020, 16'd3);
        @(posedge clk); #1;
        chk("basic.valid_drop", 16'(valid_out), 16'd0);

        // 2-point cluster is dropped, next cluster starts empty
        send(16'h0010, 16'h0010, 16'h0010, 1'b0);
        send(16'h0020, 16'h0020, 16'h0020, 1'b1);
        chk("drop2.pulse", 16'(dropped_out), 16'd1);
        chk("drop2.valid", 16'(valid_out), 16'd0);
        @(posedge clk); #1;
        chk("drop2.pulse_end", 16'(dropped_out), 16'd0);
        send(16'h0005, 16'h0006, 16'h0007, 1'b0);
        send(16'h0001, 16'h0002, 16'h0003, 1'b0);
        send(16'h0009, 16'h0008, 16'h0004, 1'b1);
        chk_box("after_drop", 16'h0001, 16'h0002, 16'h0003, 16'h0009, 16'h0008, 16'h0007, 16'd3);
        send(16'h1111, 16'h2222, 16'h3333, 1'b1);
        chk("single.dropped", 16'(dropped_out), 16'd1);
        @(posedge clk); #1;

        // Stall: box pending with ready_in low blocks the next cluster
        ready_in = 1'b0;
        send(16'h0100, 16'h0100, 16'h0100, 1'b0);
        send(16'h0200, 16'h0200, 16'h0200, 1'b0);
        send(16'h0300, 16'h0300, 16'h0300, 1'b1);
        chk_box("stallA", 16'h0100, 16'h0100, 16'h0100, 16'h0300, 16'h0300, 16'h0300, 16'd3);
        pt_valid_in = 1'b1; pt_x = 16'hFFF0; pt_y = 16'h0000; pt_z = 16'h0000; pt_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall.ready", 16'(pt_ready_out), 16'd0);
            chk("stall.valid", 16'(valid_out), 16'd1);
            chk("stall.min_x", min_x, 16'h0100);
            chk("stall.max_x", max_x, 16'h0300);
            chk("stall.count", 16'(point_count), 16'd3);
        end
        ready_in = 1'b1;
        #1;
        chk("stall.release_ready", 16'(pt_ready_out), 16'd1);
        @(posedge clk); #1;
        pt_valid_in = 1'b0;
        chk("stall.handshake", 16'(valid_out), 16'd0);
        send(16'h0010, 16'h0020, 16'h0030, 1'b0);
        send(16'h0005, 16'hFFF0, 16'h0040, 1'b1);
        chk_box("stallB", 16'hFFF0, 16'hFFF0, 16'h0000, 16'h0010, 16'h0020, 16'h0040, 16'd3);
        @(posedge clk); #1;

        // Back-to-back single-point boxes on the MIN_POINTS=1 instance
        b_ready_in = 1'b1;
        b_valid_in = 1'b1; b_last = 1'b1; b_x = 16'h0123; b_y = 16'h0456; b_z = 16'hF789;
        @(posedge clk); #1;
        chk("b2b.A.valid", 16'(b_valid_out), 16'd1);
        chk("b2b.A.min_x", b_min_x, 16'h0123);
        chk("b2b.A.max_x", b_max_x, 16'h0123);
        chk("b2b.A.min_z", b_min_z, 16'hF789);
        chk("b2b.A.count", 16'(b_count), 16'd1);
        b_x = 16'h0AAA; b_y = 16'h0BBB; b_z = 16'h0CCC;
        @(posedge clk); #1;
        b_valid_in = 1'b0; b_last = 1'b0;
        chk("b2b.B.valid", 16'(b_valid_out), 16'd1);
        chk("b2b.B.min_x", b_min_x, 16'h0AAA);
        chk("b2b.B.max_y", b_max_y, 16'h0BBB);
        chk("b2b.B.max_z", b_max_z, 16'h0CCC);
        chk("b2b.B.dropped", 16'(b_dropped), 16'd0);
        @(posedge clk); #1;
        chk("b2b.end.valid", 16'(b_valid_out), 16'd0);

        // Reset mid-cluster with 5 points accumulated
        for (int i = 0; i < 5; i++)
            send(16'h0700, 16'h0700, 16'h0700, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid.valid", 16'(valid_out), 16'd0);
        chk("rstmid.min_x", min_x, 16'h0000);
        chk("rstmid.max_y", max_y, 16'h0000);
        chk("rstmid.count", 16'(point_count), 16'd0);
        rst = 1'b0;
        send(16'h0001, 16'h0001, 16'h0001, 1'b0);
        send(16'h0002, 16'h0002, 16'h0002, 1'b0);
        send(16'h0003, 16'h0003, 16'h0003, 1'b1);
        chk_box("post_rst", 16'h0001, 16'h0001, 16'h0001, 16'h0003, 16'h0003, 16'h0003, 16'd3);
        @(posedge clk); #1;

        // Reset while a box is pending
        ready_in = 1'b0;
        send(16'h0040, 16'h0040, 16'h0040, 1'b0);
        send(16'h0041, 16'h0041, 16'h0041, 1'b0);
        send(16'h0042, 16'h0042, 16'h0042, 1'b1);
        chk("pend.valid", 16'(valid_out), 16'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("pend_rst.valid", 16'(valid_out), 16'd0);
        chk("pend_rst.max_x", max_x, 16'h0000);
        rst = 1'b0;
        ready_in = 1'b1;

        // Box near full scale: exact in the default build, saturated with the margin
        send(16'h7FF0, 16'h8010, 16'h0040, 1'b0);
        send(16'h0010, 16'h0100, 16'h0050, 1'b0);
        send(16'h0000, 16'h0000, 16'h0060, 1'b1);
`ifdef BBOX_MARGIN_EN
        chk_box("margin", 16'hFFE0, 16'h8000, 16'h0020, 16'h7FFF, 16'h0120, 16'h0080, 16'd3);
`else
        chk_box("edge", 16'h0000, 16'h8010, 16'h0040, 16'h7FF0, 16'h0100, 16'h0060, 16'd3);
`endif
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
